// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: redirect controls and PC-state outputs between the control path and the PC unit.
interface pc_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_WIDTH = 32
);
  logic stall;
  logic branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic jump;
  logic [WIDTH-1:0] jump_target;
  logic exc_req;
  logic eret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_inc;
  logic [WIDTH-1:0] epc;
  logic in_trap;
  logic misaligned;
  logic [CNT_WIDTH-1:0] update_count;
  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, exc_req, eret,
    input pc, pc_plus_inc, epc, in_trap, misaligned, update_count
  );
  modport slave (
    input stall, branch_taken, branch_target, jump, jump_target, exc_req, eret,
    output pc, pc_plus_inc, epc, in_trap, misaligned, update_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with reset vector, stall, prioritised redirects and a RUN/TRAP machine.
module pc_sequencer #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h00400000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = 32'h80000180,
  parameter int INC = 4,
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  pc_sequencer_if.slave bus
);
  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;
  state_t r_state = RUN;
  state_t w_state_nx;
  logic [WIDTH-1:0] r_pc = RESET_VECTOR;
  logic [WIDTH-1:0] r_epc = '0;
  logic r_mis = 1'b0;
  logic [CNT_WIDTH-1:0] r_cnt = '0;
  logic [WIDTH-1:0] w_pc_inc, w_sel, w_pc_nx, w_epc_nx;
  logic w_redir, w_mis, w_trap_entry, w_ret, w_upd, w_mis_nx;
  always_comb begin
    w_pc_inc = r_pc + WIDTH'(INC);
    w_sel = bus.jump ? bus.jump_target : bus.branch_target;
    w_redir = bus.jump | bus.branch_taken;
    w_mis = w_redir & (w_sel[1:0] != 2'b00);
    w_trap_entry = (r_state == RUN) & (bus.exc_req | w_mis);
    w_ret = (r_state == TRAP) & ~bus.stall & bus.eret;
  end
  always_comb begin
    w_state_nx = w_trap_entry ? TRAP : w_ret ? RUN : r_state;
  end
  // eret in RUN is a no-op that still advances sequentially, ahead of jump/branch
  always_comb begin
    w_pc_nx = w_trap_entry ? TRAP_VECTOR :
              bus.stall ? r_pc :
              bus.eret ? ((r_state == TRAP) ? r_epc : w_pc_inc) :
              w_redir ? w_sel : w_pc_inc;
    w_epc_nx = w_trap_entry ? r_pc : r_epc;
    w_mis_nx = w_trap_entry ? (r_mis | w_mis) : w_ret ? 1'b0 : r_mis;
    w_upd = w_trap_entry | ~bus.stall;
    bus.pc = r_pc;
    bus.pc_plus_inc = w_pc_inc;
    bus.epc = r_epc;
    bus.in_trap = (r_state == TRAP);
    bus.misaligned = r_mis;
    bus.update_count = r_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_pc <= RESET_VECTOR;
      r_epc <= '0;
      r_mis <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc <= w_pc_nx;
      r_epc <= w_epc_nx;
      r_mis <= w_mis_nx;
      r_cnt <= r_cnt + CNT_WIDTH'(w_upd);
    end
  end
endmodule
